// File: rtl/registro_pkg.sv
// Shared constants and state type for the N-bit universal shift register.
package registro_pkg;

    localparam logic [1:0] MODO_SERIE = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_CARGA = 2'b10;
    localparam logic [1:0] MODO_HOLD  = 2'b11;

    localparam logic DIR_IZQ = 1'b0;
    localparam logic DIR_DER = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

endpackage

// File: rtl/desplazador_paso.sv
// One combinational step of the register: serial shift, rotate, load or hold.
// Shared by direct mode and burst mode so both produce identical results.
module desplazador_paso
    import registro_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [1:0]       i_modo,
    input  logic             i_dir,
    input  logic             i_s_in,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_out_bit
);

    logic w_in_bit;

    // Outgoing bit depends only on direction; rotate feeds it back in.
    always_comb begin
        o_out_bit = (i_dir == DIR_DER) ? i_q[0] : i_q[WIDTH-1];
        w_in_bit  = (i_modo == MODO_ROT) ? o_out_bit : i_s_in;
        o_next_q  = i_q;
        unique case (i_modo)
            MODO_SERIE, MODO_ROT: begin
                if (i_dir == DIR_DER) begin
                    o_next_q = {w_in_bit, i_q[WIDTH-1:1]};
                end else begin
                    o_next_q = {i_q[WIDTH-2:0], w_in_bit};
                end
            end
            MODO_CARGA: o_next_q = i_d;
            default:    o_next_q = i_q;
        endcase
    end

endmodule

// File: rtl/registro_desplazante_n.sv
// WIDTH-bit universal shift register with a burst sequencer that repeats a
// shift or rotation a programmed number of times and flags busy/done.
module registro_desplazante_n
    import registro_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [CNT_W-1:0] cuenta,
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    estado_t          r_estado, w_estado_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_modo, w_modo_nxt;
    logic             r_dir, w_dir_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_s_out, w_s_out_nxt;
    logic             r_busy;
    logic             r_done, w_done_nxt;

    logic             w_start_ok;
    logic [1:0]       w_modo_paso;
    logic             w_dir_paso;
    logic [WIDTH-1:0] w_paso_q;
    logic             w_paso_bit;

    // Burst controls come from the latched copy while running.
    assign w_modo_paso = (r_estado == RUN) ? r_modo : modo;
    assign w_dir_paso  = (r_estado == RUN) ? r_dir  : dir;
    assign w_start_ok  = (r_estado == IDLE) && start &&
                         ((modo == MODO_SERIE) || (modo == MODO_ROT));

    desplazador_paso #(.WIDTH(WIDTH)) u_paso (
        .i_q       (r_q),
        .i_modo    (w_modo_paso),
        .i_dir     (w_dir_paso),
        .i_s_in    (s_in),
        .i_d       (d),
        .o_next_q  (w_paso_q),
        .o_out_bit (w_paso_bit)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
            r_cnt    <= '0;
            r_modo   <= MODO_SERIE;
            r_dir    <= DIR_IZQ;
            r_q      <= '0;
            r_s_out  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            r_cnt    <= w_cnt_nxt;
            r_modo   <= w_modo_nxt;
            r_dir    <= w_dir_nxt;
            r_q      <= w_q_nxt;
            r_s_out  <= w_s_out_nxt;
            r_busy   <= (w_estado_nxt == RUN);
            r_done   <= w_done_nxt;
        end
    end

    // Next-state: direct operation or burst acceptance in IDLE, stepping in RUN.
    always_comb begin
        w_estado_nxt = r_estado;
        w_cnt_nxt    = r_cnt;
        w_modo_nxt   = r_modo;
        w_dir_nxt    = r_dir;
        w_q_nxt      = r_q;
        w_s_out_nxt  = r_s_out;
        w_done_nxt   = 1'b0;
        unique case (r_estado)
            IDLE: begin
                if (w_start_ok) begin
                    w_modo_nxt = modo;
                    w_dir_nxt  = dir;
                    w_cnt_nxt  = cuenta;
                    if (cuenta == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_estado_nxt = RUN;
                    end
                end else if (enb) begin
                    w_q_nxt = w_paso_q;
                    if ((modo == MODO_SERIE) || (modo == MODO_ROT)) begin
                        w_s_out_nxt = w_paso_bit;
                    end
                end
            end
            RUN: begin
                if (enb) begin
                    w_q_nxt     = w_paso_q;
                    w_s_out_nxt = w_paso_bit;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_estado_nxt = IDLE;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            default: w_estado_nxt = IDLE;
        endcase
    end

    assign q     = r_q;
    assign s_out = r_s_out;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_registro_desplazante_n.sv
// Scoreboard bench for registro_desplazante_n (WIDTH = 8) with a queue-based
// reference model and a decoupled negedge monitor.
module tb_registro_desplazante_n;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [1:0] modo;
    logic [7:0] d;
    logic       start;
    logic [3:0] cuenta;
    logic [7:0] q;
    logic       s_out;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (plain integers).
    int m_q, m_so, m_busy, m_done, m_rem, m_mode, m_dir;

    registro_desplazante_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enb    (enb),
        .dir    (dir),
        .s_in   (s_in),
        .modo   (modo),
        .d      (d),
        .start  (start),
        .cuenta (cuenta),
        .q      (q),
        .s_out  (s_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge compares the DUT outputs with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({q, s_out, busy, done} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got q=%h s_out=%b busy=%b done=%b expected q=%h s_out=%b busy=%b done=%b",
                         $time, q, s_out, busy, done, e.q, e.so, e.bsy, e.dn);
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0; m_dir = 0;
    endtask

    // One shift/rotate/load using arithmetic on the integer value.
    task automatic apply(input int md, input int dr, input int si, input int dd);
        int outb, inb;
        if (md == 2) begin
            m_q = dd;
        end else if (md < 2) begin
            outb = (dr == 1) ? (m_q % 2) : (m_q / 128);
            inb  = (md == 1) ? outb : si;
            if (dr == 1) m_q = m_q / 2 + inb * 128;
            else         m_q = (m_q * 2 + inb) % 256;
            m_so = outb;
        end
    endtask

    task automatic model_step(input int e, input int dr, input int si, input int md,
                              input int dd, input int st, input int cu);
        int nd;
        nd = 0;
        if (m_busy == 0) begin
            if (st != 0 && md < 2) begin
                m_mode = md;
                m_dir  = dr;
                if (cu == 0) nd = 1;
                else begin
                    m_busy = 1;
                    m_rem  = cu;
                end
            end else if (e != 0) begin
                apply(md, dr, si, dd);
            end
        end else if (e != 0) begin
            apply(m_mode, m_dir, si, 0);
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                nd     = 1;
            end
        end
        m_done = nd;
    endtask

    // Drive one cycle of inputs, predict, and queue the expectation.
    task automatic cyc(input logic e, input logic dr, input logic si, input logic [1:0] md,
                       input logic [7:0] dd, input logic st, input logic [3:0] cu);
        exp_t x;
        enb = e; dir = dr; s_in = si; modo = md; d = dd; start = st; cuenta = cu;
        model_step(int'(e), int'(dr), int'(si), int'(md), int'(dd), int'(st), int'(cu));
        x.q   = 8'(m_q);
        x.so  = 1'(m_so);
        x.bsy = 1'(m_busy);
        x.dn  = 1'(m_done);
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_s_out", int'(s_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        model_reset();
        enb = 1'b0; start = 1'b0; modo = 2'b11;
        sb.push_back('0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enb = 1'b0; dir = 1'b0; s_in = 1'b0; modo = 2'b11;
        d = '0; start = 1'b0; cuenta = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // 1: load then async reset
        cyc(1, 0, 0, 2'b10, 8'hA5, 0, 0);
        chk("load_a5", int'(q), 8'hA5);
        do_reset();

        // 2: load 0x81, serial left with s_in = 1
        cyc(1, 0, 0, 2'b10, 8'h81, 0, 0);
        cyc(1, 0, 1, 2'b00, 8'h00, 0, 0);
        chk("serial_left_q", int'(q), 8'h03);
        chk("serial_left_s_out", int'(s_out), 1);

        // 3: burst rotate right by 3 from 0x01
        cyc(1, 0, 0, 2'b10, 8'h01, 0, 0);
        cyc(1, 1, 0, 2'b01, 8'h00, 1, 3);
        repeat (3) cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);
        chk("rot_burst_q", int'(q), 8'h20);
        chk("rot_burst_done", int'(done), 1);
        cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);

        // 4: serial left burst of 4 with a 2-cycle pause
        cyc(1, 0, 0, 2'b10, 8'hFF, 0, 0);
        cyc(1, 0, 0, 2'b00, 8'h00, 1, 4);
        cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);
        cyc(0, 0, 0, 2'b11, 8'h00, 0, 0);
        cyc(0, 0, 0, 2'b11, 8'h00, 0, 0);
        repeat (3) cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);
        chk("pause_burst_q", int'(q), 8'hF0);
        chk("pause_burst_done", int'(done), 1);

        // 5: zero count, start while busy, input changes during RUN
        cyc(1, 0, 0, 2'b00, 8'h00, 1, 0);
        chk("zero_cnt_done", int'(done), 1);
        cyc(1, 1, 1, 2'b01, 8'h00, 1, 3);
        cyc(1, 0, 0, 2'b00, 8'h55, 1, 1);
        cyc(1, 0, 1, 2'b10, 8'hAA, 0, 7);
        cyc(1, 1, 0, 2'b00, 8'h33, 0, 2);
        cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);

        // 6: reset mid-burst, then a normal burst
        cyc(1, 0, 0, 2'b10, 8'h3C, 0, 0);
        cyc(1, 0, 0, 2'b01, 8'h00, 1, 5);
        cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);
        cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);
        do_reset();
        repeat (3) cyc(1, 0, 0, 2'b11, 8'h00, 0, 0);
        cyc(1, 0, 1, 2'b00, 8'h00, 1, 2);
        repeat (3) cyc(1, 0, 1, 2'b11, 8'h00, 0, 0);

        // Random traffic including counts beyond WIDTH
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                2'($urandom), 8'($urandom), 1'($urandom_range(0, 5) == 0),
                4'($urandom_range(0, 12)));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/registro_desplazante_n.md
# registro_desplazante_n

Parametrised successor to the 4-bit universal shift register: a WIDTH-bit register with serial shift, circular rotation, parallel load and hold, plus a burst sequencer that applies a shift or rotation a programmed number of times and reports completion through busy/done. It sits wherever the design needs multi-position shifts without the surrounding logic counting clocks, for example serialisers and barrel-style alignment over several cycles.

## Interface
- WIDTH, 8: register width in bits (≥ 2).
- CNT_W, $clog2(WIDTH)+1: width of the burst count; must be able to hold the value WIDTH.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- enb  in  1  clock enable for all register updates; when 0, q, s_out and a running burst all hold.
- dir  in  1  direction: 0 = left (toward MSB), 1 = right (toward LSB).
- s_in  in  1  serial input bit for serial mode.
- modo  in  2  00 serial shift, 01 rotate, 10 parallel load, 11 hold.
- d  in  WIDTH  parallel load data.
- start  in  1  one-cycle request to begin a burst.
- cuenta  in  CNT_W  number of steps in the burst.
- q  out  WIDTH  register contents.
- s_out  out  1  registered bit most recently shifted or rotated out.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse marking burst completion.

## Operation
- **Reset:** q = 0, s_out = 0, busy = 0, done = 0, FSM = IDLE, step counter = 0.
- **Direct mode (IDLE, no accepted start):** each edge with enb = 1 applies modo once.
  - 00 left: q ← {q[WIDTH-2:0], s_in}, s_out ← q[WIDTH-1].
  - 00 right: q ← {s_in, q[WIDTH-1:1]}, s_out ← q[0].
  - 01: same as 00 but the outgoing bit re-enters at the opposite end; s_out ← the outgoing bit.
  - 10: q ← d; s_out unchanged.
  - 11: all hold.
- **Burst start:** start is accepted only in IDLE and only with modo ∈ {00, 01}. Acceptance does not depend on enb.
  - On the accepting edge, the block latches modo, dir and cuenta into mode_r, dir_r and cnt. q is not changed.
  - If cuenta = 0: no steps are taken, done = 1 for the next cycle, busy stays 0.
  - If cuenta > 0: FSM → RUN, busy = 1.
  - start with modo 10/11, or while busy, is ignored. In that case direct mode applies normally.
- **RUN:**
  - Each edge with enb = 1 applies one step of mode_r/dir_r, with s_in sampled live, and decrements cnt.
  - enb = 0 pauses the burst: no step and no decrement.
  - While in RUN, the modo, dir, d and cuenta inputs are ignored.
  - On the edge that brings cnt to 0: FSM → IDLE, busy = 0, done = 1 for exactly one cycle.
- **Count range:** cuenta may exceed WIDTH. Rotation then wraps modulo WIDTH. In serial mode, every original bit is flushed out.
- **Reset mid-burst:** aborts immediately to the reset state; no done pulse is produced.

## Timing
- Direct operations take effect on the same edge they are sampled; q is valid one edge later.
- A burst of k > 0 steps with no pauses:
  - busy is high for k cycles, starting the cycle after the accepting edge.
  - done is high in the cycle after the last step; busy is already 0 in that cycle.
  - Total latency from the start edge to the done edge: k+1 edges, plus one edge for every paused cycle.
- A new start may be accepted in the same cycle that done is high, because the FSM is already in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `registro_pkg`:**
  - Mode constants: MODO_SERIE = 2'b00, MODO_ROT = 2'b01, MODO_CARGA = 2'b10, MODO_HOLD = 2'b11.
  - Direction constants: DIR_IZQ = 0, DIR_DER = 1.
  - FSM state typedef: IDLE, RUN.
- **Sub-module `desplazador_paso`:** purely combinational, parametrised by WIDTH. Takes q, modo, dir, s_in, d and produces next_q and out_bit. It is shared between direct mode and RUN, so that both paths produce bit-identical results.
- **Top level:** FSM, step counter, latched burst controls, and the q/s_out/done registers.

## Test plan
All scenarios use WIDTH = 8.
1. Load then async reset: load q = 0xA5, then assert rst_n low between clock edges → q = 0x00, s_out = 0, busy = 0, done = 0 immediately, without waiting for a clock edge.
2. Parallel load and serial left: modo = 10, d = 0x81 → q = 0x81. Then modo = 00, dir = 0, s_in = 1, one edge → q = 0x03, s_out = 1.
3. Burst rotate right: q = 0x01, start with modo = 01, dir = 1, cuenta = 3 → busy high for 3 cycles, q goes 0x80, 0x40, 0x20, then done high for exactly 1 cycle.
4. Burst with pause: serial left, s_in = 0, cuenta = 4 on q = 0xFF, with enb = 0 for 2 cycles mid-burst → q = 0xF0, done arrives 2 cycles later than in the unpaused case, and q holds during the pause.
5. Zero count and ignored requests:
   - cuenta = 0 → done pulses the next cycle, q is unchanged, busy never rises.
   - start asserted while busy → ignored; the running burst finishes at its original count.
   - modo/d changes during RUN → no effect.
6. Reset mid-burst: rst_n low during RUN → returns to IDLE with all outputs 0. No done pulse appears afterward; the next start behaves normally.
